// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream, instruction-memory write and status bundle for imem_loader
interface imem_loader_if;
    logic        ByteValid;
    logic [7:0]  ByteData;
    logic        ByteReady;
    logic        Restart;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        CpuRst;
    logic        Done;
    logic        Error;

    modport master (
        input  ByteValid, ByteData, Restart,
        output ByteReady, MemWrite, MemAddr, MemWData, CpuRst, Done, Error
    );

    modport slave (
        output ByteValid, ByteData, Restart,
        input  ByteReady, MemWrite, MemAddr, MemWData, CpuRst, Done, Error
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: header, big-endian words and XOR checksum into instruction memory
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MAX_WORDS = 32'd1024
) (
    input  logic            Clk,
    input  logic            Rst,
    imem_loader_if.master   bus
);
    typedef enum logic [2:0] {
        S_HDR_HI, S_HDR_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] nwords_q, nwords_d;
    logic [23:0] shift_q, shift_d;

    logic        fire;
    logic [15:0] hdr;
    logic [31:0] hdr32;

    assign fire  = bus.ByteValid && ready_q;
    assign hdr   = {nwords_q[15:8], bus.ByteData};
    assign hdr32 = {16'd0, hdr};

    always_comb begin
        state_d  = state_q;
        csum_d   = csum_q;
        idx_d    = idx_q;
        lane_d   = lane_q;
        nwords_d = nwords_q;
        shift_d  = shift_q;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_HDR_HI: begin
                if (fire) begin
                    nwords_d[15:8] = bus.ByteData;
                    csum_d         = csum_q ^ bus.ByteData;
                    state_d        = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (fire) begin
                    nwords_d[7:0] = bus.ByteData;
                    csum_d        = csum_q ^ bus.ByteData;
                    if (hdr32 > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (hdr == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = 16'd0;
                        lane_d  = 2'd0;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    csum_d = csum_q ^ bus.ByteData;
                    if (lane_q == 2'd3) begin
                        // Fourth byte completes the word; the write strobe follows next cycle
                        wr_d    = 1'b1;
                        wdata_d = {shift_q, bus.ByteData};
                        addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        idx_d   = idx_q + 16'd1;
                        lane_d  = 2'd0;
                        if (idx_q == nwords_q - 16'd1) begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        shift_d = {shift_q[15:0], bus.ByteData};
                        lane_d  = lane_q + 2'd1;
                    end
                end
            end
            S_CHECK: begin
                if (fire) begin
                    state_d = (bus.ByteData == csum_q) ? S_DONE : S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (bus.Restart) begin
                    state_d = S_HDR_HI;
                    csum_d  = 8'd0;
                    idx_d   = 16'd0;
                    lane_d  = 2'd0;
                end
            end
            default: state_d = S_ERROR;
        endcase
        // Registered ready tracks the state being entered so bytes stream without bubbles
        ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
                  (state_d == S_DATA)   || (state_d == S_CHECK);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= S_HDR_HI;
            ready_q  <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= 32'd0;
            csum_q   <= 8'd0;
            idx_q    <= 16'd0;
            lane_q   <= 2'd0;
            nwords_q <= 16'd0;
            shift_q  <= 24'd0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            csum_q   <= csum_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            nwords_q <= nwords_d;
            shift_q  <= shift_d;
        end
    end

    assign bus.ByteReady = ready_q;
    assign bus.MemWrite  = wr_q;
    assign bus.MemAddr   = addr_q;
    assign bus.MemWData  = wdata_q;
    assign bus.Done      = (state_q == S_DONE);
    assign bus.Error     = (state_q == S_ERROR);
    assign bus.CpuRst    = (state_q != S_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a byte-sequence reference model
module tb_imem_loader;
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        bv [2];
    logic [7:0]  bd [2];
    logic        rs [2];
    logic        rdy [2];
    logic        wr [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        done [2];
    logic        err [2];
    logic        crst [2];

    int n_checks = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    imem_loader_if if_a ();
    imem_loader_if if_b ();

    assign if_a.ByteValid = bv[0];
    assign if_a.ByteData  = bd[0];
    assign if_a.Restart   = rs[0];
    assign if_b.ByteValid = bv[1];
    assign if_b.ByteData  = bd[1];
    assign if_b.Restart   = rs[1];
    assign rdy[0] = if_a.ByteReady;  assign rdy[1] = if_b.ByteReady;
    assign wr[0]  = if_a.MemWrite;   assign wr[1]  = if_b.MemWrite;
    assign addr[0] = if_a.MemAddr;   assign addr[1] = if_b.MemAddr;
    assign wdata[0] = if_a.MemWData; assign wdata[1] = if_b.MemWData;
    assign done[0] = if_a.Done;      assign done[1] = if_b.Done;
    assign err[0]  = if_a.Error;     assign err[1]  = if_b.Error;
    assign crst[0] = if_a.CpuRst;    assign crst[1] = if_b.CpuRst;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(32'd4)) u_a (
        .Clk(Clk), .Rst(Rst), .bus(if_a.master));
    imem_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(32'd1024)) u_b (
        .Clk(Clk), .Rst(Rst), .bus(if_b.master));

    function automatic logic [31:0] base_of(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? 4 : 1024;
    endfunction

    // Reference model: the list of bytes consumed since reset/restart determines everything
    logic [7:0]  m_b [2][64];
    int          m_k [2];
    bit          m_st [2];
    logic        m_wr [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];

    // 0 HDR_HI, 1 HDR_LO, 2 DATA, 3 CHECK, 4 DONE, 5 ERROR
    function automatic int phase(input int i);
        int k;
        int n;
        logic [7:0] x;
        k = m_k[i];
        if (k == 0) return 0;
        if (k == 1) return 1;
        n = int'({m_b[i][0], m_b[i][1]});
        if (n > max_of(i)) return 5;
        if (k < 2 + 4 * n) return 2;
        if (k == 2 + 4 * n) return 3;
        x = 8'd0;
        for (int j = 0; j < k - 1; j++) x = x ^ m_b[i][j];
        return (m_b[i][k-1] == x) ? 4 : 5;
    endfunction

    function automatic bit m_ready(input int i);
        return m_st[i] && (phase(i) <= 3);
    endfunction

    initial forever begin
        @(posedge Clk or negedge Rst);
        for (int i = 0; i < 2; i++) begin
            if (!Rst) begin
                m_k[i] = 0; m_st[i] = 0; m_wr[i] = 0;
                m_addr[i] = base_of(i); m_data[i] = 32'd0;
            end else begin
                m_wr[i] = 0;
                if (bv[i] && m_ready(i) && m_k[i] < 64) begin
                    int k;
                    int n;
                    m_b[i][m_k[i]] = bd[i];
                    m_k[i] = m_k[i] + 1;
                    k = m_k[i];
                    n = (k >= 2) ? int'({m_b[i][0], m_b[i][1]}) : 0;
                    if (k >= 6 && (k - 2) % 4 == 0 && (k - 2) / 4 <= n) begin
                        m_wr[i]   = 1;
                        m_addr[i] = base_of(i) + 32'(((k - 2) / 4 - 1) * 4);
                        m_data[i] = {m_b[i][k-4], m_b[i][k-3], m_b[i][k-2], m_b[i][k-1]};
                    end
                end else if (rs[i] && phase(i) >= 4) begin
                    m_k[i] = 0;
                end
                m_st[i] = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    logic [31:0] la0 [$];
    logic [31:0] ld0 [$];
    logic [31:0] la1 [$];

    initial forever begin
        @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(m_ready(i)));
            chk($sformatf("memwrite[%0d]", i), 32'(wr[i]), 32'(m_wr[i]));
            chk($sformatf("memaddr[%0d]", i), addr[i], m_addr[i]);
            chk($sformatf("memwdata[%0d]", i), wdata[i], m_data[i]);
            chk($sformatf("done[%0d]", i), 32'(done[i]), 32'(phase(i) == 4));
            chk($sformatf("error[%0d]", i), 32'(err[i]), 32'(phase(i) == 5));
            chk($sformatf("cpurst[%0d]", i), 32'(crst[i]), 32'(phase(i) != 4));
        end
        if (wr[0] === 1'b1) begin la0.push_back(addr[0]); ld0.push_back(wdata[0]); end
        if (wr[1] === 1'b1) la1.push_back(addr[1]);
    end

    task automatic send(input int i, input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin @(negedge Clk); bv[i] = 1'b0; end
        @(negedge Clk);
        bv[i] = 1'b1;
        bd[i] = b;
        t = 0;
        while (rdy[i] !== 1'b1 && t < 100) begin @(negedge Clk); t++; end
        chk("send_timeout", 32'(t >= 100), 32'd0);
        if (t < 100) @(posedge Clk);
    endtask

    task automatic send_list(input int i, input logic [7:0] q [$], input bit rnd);
        foreach (q[j]) send(i, q[j], rnd ? int'($urandom_range(0, 2)) : 0);
        @(negedge Clk);
        bv[i] = 1'b0;
    endtask

    task automatic pulse_restart(input int i);
        @(negedge Clk); rs[i] = 1'b1;
        @(negedge Clk); rs[i] = 1'b0;
    endtask

    initial begin
        bv[0] = 0; bv[1] = 0; bd[0] = 0; bd[1] = 0; rs[0] = 0; rs[1] = 0;
        repeat (3) @(negedge Clk);
        chk("reset_ready", 32'(rdy[0]), 32'd0);
        chk("reset_cpurst", 32'(crst[0]), 32'd1);
        chk("reset_addr_b", addr[1], 32'hFFFF_FFFC);
        Rst = 1'b1;

        send_list(0, '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09}, 0);
        chk("t1_done", 32'(done[0]), 32'd1);
        chk("t1_cpurst", 32'(crst[0]), 32'd0);
        chk("t1_nwrites", 32'(la0.size()), 32'd1);
        chk("t1_addr", la0[0], 32'h0);
        chk("t1_data", ld0[0], 32'h1234_5678);
        la0.delete(); ld0.delete();
        pulse_restart(0);

        send_list(0, '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                       8'h01, 8'h02, 8'h03, 8'h04, 8'h06}, 1);
        chk("t2_done", 32'(done[0]), 32'd1);
        chk("t2_nwrites", 32'(la0.size()), 32'd2);
        chk("t2_data0", ld0[0], 32'hAABB_CCDD);
        chk("t2_addr1", la0[1], 32'h4);
        chk("t2_data1", ld0[1], 32'h0102_0304);
        la0.delete(); ld0.delete();
        pulse_restart(0);

        send_list(0, '{8'h00, 8'h00, 8'h00}, 0);
        chk("t3_done", 32'(done[0]), 32'd1);
        chk("t3_nwrites", 32'(la0.size()), 32'd0);
        pulse_restart(0);
        send_list(0, '{8'h00, 8'h00, 8'h01}, 0);
        chk("t3_error", 32'(err[0]), 32'd1);
        chk("t3_cpurst", 32'(crst[0]), 32'd1);
        chk("t3_ready", 32'(rdy[0]), 32'd0);
        pulse_restart(0);

        send_list(0, '{8'h00, 8'h05}, 0);
        chk("t4_overflow_error", 32'(err[0]), 32'd1);
        chk("t4_nwrites", 32'(la0.size()), 32'd0);
        pulse_restart(0);
        send_list(0, '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09}, 0);
        chk("t4_done", 32'(done[0]), 32'd1);
        la0.delete(); ld0.delete();
        pulse_restart(0);

        send(0, 8'h00, 0); send(0, 8'h01, 0); send(0, 8'h12, 0); send(0, 8'h34, 0);
        #2 Rst = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(rdy[0]), 32'd0);
        chk("t5_rst_memwrite", 32'(wr[0]), 32'd0);
        chk("t5_rst_addr", addr[0], 32'h0);
        chk("t5_rst_wdata", wdata[0], 32'h0);
        chk("t5_rst_cpurst", 32'(crst[0]), 32'd1);
        bv[0] = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        send_list(0, '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23}, 0);
        chk("t5_done", 32'(done[0]), 32'd1);
        chk("t5_nwrites", 32'(la0.size()), 32'd1);
        chk("t5_data", ld0[0], 32'hDEAD_BEEF);

        send_list(1, '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                       8'h55, 8'h66, 8'h77, 8'h88, 8'h8A}, 0);
        chk("t6_done", 32'(done[1]), 32'd1);
        chk("t6_nwrites", 32'(la1.size()), 32'd2);
        chk("t6_addr0", la1[0], 32'hFFFF_FFFC);
        chk("t6_addr1", la1[1], 32'h0000_0000);

        repeat (3) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
